cnn_weight_streamer: RTL

//  Transmit side of the filter-weight load path. Takes weight words from an upstream stream
//  (DMA/AXI side), two elements per beat, and delivers them to the per-filter weight buffers.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/cnn_weight_streamer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: op-code field positions and weight-streamer state encoding.
package cnn_pkg;

    localparam int unsigned OPC_NF_LSB = 3;
    localparam int unsigned OPC_NF_MSB = 7;
    localparam int unsigned OPC_NE_LSB = 8;
    localparam int unsigned OPC_NE_MSB = 13;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_STREAM,
        WS_GAP,
        WS_DONE
    } ws_state_t;

endpackage

// File: rtl/cnn_weight_streamer.sv
// Streams two-element weight beats from the DMA side into the per-filter weight buffers,
// with a one-hot filter select, lane valids, end-of-filter marker and a done pulse.
module cnn_weight_streamer
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MAX_FILTERS = 32,
    parameter int unsigned ELEM_W      = 6,
    parameter int unsigned FILT_W      = 5
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   start_i,
    input  logic [13:0]            op_code_i,
    input  logic [2*DATA_W-1:0]    s_data_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    output logic [2*DATA_W-1:0]    w_data_o,
    output logic                   w_lane0_vld_o,
    output logic                   w_lane1_vld_o,
    output logic [MAX_FILTERS-1:0] weight_en_o,
    output logic                   filter_last_o,
    output logic                   busy_o,
    output logic                   done_o
);

    ws_state_t                state_q, state_nx;
    logic [FILT_W-1:0]        f_idx_q, f_idx_nx;
    logic [ELEM_W-1:0]        beat_cnt_q, beat_cnt_nx;
    logic [FILT_W-1:0]        nf_q, nf_nx;
    logic [ELEM_W-1:0]        ne_q, ne_nx;

    logic [2*DATA_W-1:0]      w_data_nx;
    logic                     lane0_nx, lane1_nx, last_nx;
    logic                     busy_nx, done_nx, ready_nx;
    logic [MAX_FILTERS-1:0]   en_nx;

    logic [FILT_W-1:0]        nf_raw, nf_op;
    logic [ELEM_W-1:0]        ne_op, beats_m1;
    logic                     beat_last, filt_last, xfer;
    logic                     unused_opc;

    assign unused_opc = ^op_code_i[OPC_NF_LSB-1:0];

    // Op-code decode; NF clamped to the number of addressable buffers.
    assign nf_raw = FILT_W'(op_code_i[OPC_NF_MSB:OPC_NF_LSB]);
    assign nf_op  = (32'(nf_raw) > MAX_FILTERS) ? FILT_W'(MAX_FILTERS) : nf_raw;
    assign ne_op  = ELEM_W'(op_code_i[OPC_NE_MSB:OPC_NE_LSB]);

    // ceil(NE/2)-1 without the NE+1 overflow at NE = 2**ELEM_W-1.
    assign beats_m1  = (ne_q >> 1) + ELEM_W'(ne_q[0]) - ELEM_W'(1);
    assign beat_last = (beat_cnt_q == beats_m1);
    assign filt_last = (f_idx_q == nf_q - FILT_W'(1));
    assign xfer      = s_valid_i && (state_q == WS_STREAM);

    always_comb begin
        state_nx    = state_q;
        f_idx_nx    = f_idx_q;
        beat_cnt_nx = beat_cnt_q;
        nf_nx       = nf_q;
        ne_nx       = ne_q;
        w_data_nx   = '0;
        lane0_nx    = 1'b0;
        lane1_nx    = 1'b0;
        last_nx     = 1'b0;
        en_nx       = '0;

        case (state_q)
            WS_IDLE: begin
                if (start_i) begin
                    nf_nx       = nf_op;
                    ne_nx       = ne_op;
                    f_idx_nx    = '0;
                    beat_cnt_nx = '0;
                    state_nx    = (nf_op == '0 || ne_op == '0) ? WS_DONE : WS_STREAM;
                end
            end
            WS_STREAM: begin
                en_nx = MAX_FILTERS'(1) << f_idx_q;
                if (xfer) begin
                    lane0_nx  = 1'b1;
                    lane1_nx  = !(beat_last && ne_q[0]);
                    last_nx   = beat_last;
                    w_data_nx = {lane1_nx ? s_data_i[2*DATA_W-1:DATA_W] : {DATA_W{1'b0}},
                                 s_data_i[DATA_W-1:0]};
                    if (beat_last) begin
                        beat_cnt_nx = '0;
                        if (filt_last) begin
                            f_idx_nx = '0;
                            state_nx = WS_DONE;
                        end else begin
                            f_idx_nx = f_idx_q + FILT_W'(1);
                            state_nx = WS_GAP;
                        end
                    end else begin
                        beat_cnt_nx = beat_cnt_q + ELEM_W'(1);
                    end
                end
            end
            WS_GAP:  state_nx = WS_STREAM;
            WS_DONE: state_nx = WS_IDLE;
            default: state_nx = WS_IDLE;
        endcase

        busy_nx  = (state_nx != WS_IDLE);
        ready_nx = (state_nx == WS_STREAM);
        done_nx  = (state_q == WS_DONE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= WS_IDLE;
            f_idx_q       <= '0;
            beat_cnt_q    <= '0;
            nf_q          <= '0;
            ne_q          <= '0;
            s_ready_o     <= 1'b0;
            w_data_o      <= '0;
            w_lane0_vld_o <= 1'b0;
            w_lane1_vld_o <= 1'b0;
            weight_en_o   <= '0;
            filter_last_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            state_q       <= state_nx;
            f_idx_q       <= f_idx_nx;
            beat_cnt_q    <= beat_cnt_nx;
            nf_q          <= nf_nx;
            ne_q          <= ne_nx;
            s_ready_o     <= ready_nx;
            w_data_o      <= w_data_nx;
            w_lane0_vld_o <= lane0_nx;
            w_lane1_vld_o <= lane1_nx;
            weight_en_o   <= en_nx;
            filter_last_o <= last_nx;
            busy_o        <= busy_nx;
            done_o        <= done_nx;
        end
    end

endmodule
